// File: rtl/shared_vc_credit_ctrl_if.sv
// Shared-VC credit controller bus.
// Groups the per-port allocator/flit handshake and the exported status.
//   master : allocator/switch side, drives credits, allocs and flits.
//   slave  : the credit controller, drives availability, counts, errors.
// Port 0 of credit_count_op occupies the most significant cnt_width bits.
interface shared_vc_credit_ctrl_if #(
  parameter int unsigned num_ports = 5,
  parameter int unsigned cnt_width = 4
);
  logic [num_ports-1:0]           credit_for_shared_in;
  logic [num_ports-1:0]           alloc_op;
  logic [num_ports-1:0]           flit_valid_op;
  logic [num_ports-1:0]           flit_tail_op;
  logic [num_ports-1:0]           shared_credit_avail_op;
  logic [num_ports-1:0]           ready_for_allocation_out;
  logic [num_ports*cnt_width-1:0] credit_count_op;
  logic [num_ports-1:0]           error_op;
  logic                           error;

  modport master (
    output credit_for_shared_in, alloc_op, flit_valid_op, flit_tail_op,
    input  shared_credit_avail_op, ready_for_allocation_out,
           credit_count_op, error_op, error
  );

  modport slave (
    input  credit_for_shared_in, alloc_op, flit_valid_op, flit_tail_op,
    output shared_credit_avail_op, ready_for_allocation_out,
           credit_count_op, error_op, error
  );
endinterface

// File: rtl/shared_vc_credit_ctrl.sv
// Per-output-port credit and allocation controller for the downstream
// shared VC buffer. Tracks free downstream slots per port from delayed
// credit returns and launched flits, runs a per-port IDLE/BUSY ownership
// FSM and keeps sticky per-port error bits.
//   clk   : sole clock
//   reset : asynchronous, active-low
//   bus   : slave side of shared_vc_credit_ctrl_if (credits, alloc, flits in;
//           availability, readiness, counts, errors out)
// All outputs are decodes of registered state; error is the registered OR.
module shared_vc_credit_ctrl #(
  parameter int unsigned num_ports        = 5,
  parameter int unsigned shared_buf_depth = 8,
  parameter int unsigned credit_delay     = 1,
  parameter int unsigned alloc_threshold  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  shared_vc_credit_ctrl_if.slave  bus
);

  localparam int unsigned cnt_width = $clog2(shared_buf_depth + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [cnt_width-1:0] DEPTH  = cnt_width'(shared_buf_depth);
  localparam logic [cnt_width-1:0] THRESH = cnt_width'(alloc_threshold);
  localparam logic [cnt_width-1:0] ONE    = cnt_width'(1);

  logic [num_ports-1:0] ret;

  // Credit return pipeline; zero stages passes the raw pulse through.
  if (credit_delay == 0) begin : g_no_delay
    always_comb begin
      ret = bus.credit_for_shared_in;
    end
  end else begin : g_delay
    logic [credit_delay-1:0] pipe_q [num_ports];
    logic [credit_delay-1:0] pipe_d [num_ports];

    always_comb begin
      ret = '0;
      for (int unsigned p = 0; p < num_ports; p++) begin
        pipe_d[p] = (pipe_q[p] << 1) | credit_delay'(bus.credit_for_shared_in[p]);
        ret[p]    = pipe_q[p][credit_delay-1];
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int unsigned p = 0; p < num_ports; p++) begin
          pipe_q[p] <= '0;
        end
      end else begin
        for (int unsigned p = 0; p < num_ports; p++) begin
          pipe_q[p] <= pipe_d[p];
        end
      end
    end
  end

  logic [cnt_width-1:0] cnt_q   [num_ports];
  logic [cnt_width-1:0] cnt_d   [num_ports];
  logic [0:0]           state_q [num_ports];
  logic [0:0]           state_d [num_ports];
  logic [num_ports-1:0] err_q;
  logic [num_ports-1:0] err_d;
  logic                 error_q;
  logic                 error_d;
  logic [num_ports-1:0] ready;

  // Status decodes of registered state only.
  always_comb begin
    ready                      = '0;
    bus.shared_credit_avail_op = '0;
    bus.credit_count_op        = '0;
    for (int unsigned p = 0; p < num_ports; p++) begin
      ready[p]                      = (state_q[p] == IDLE) && (cnt_q[p] >= THRESH);
      bus.shared_credit_avail_op[p] = (cnt_q[p] != '0);
      bus.credit_count_op[(num_ports-1-p)*cnt_width +: cnt_width] = cnt_q[p];
    end
    bus.ready_for_allocation_out = ready;
    bus.error_op                 = err_q;
    bus.error                    = error_q;
  end

  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    err_d   = err_q;
    error_d = |err_q;
    for (int unsigned p = 0; p < num_ports; p++) begin
      // Counter: a simultaneous return and launch cancel, even at zero.
      if (ret[p] && !bus.flit_valid_op[p]) begin
        if (cnt_q[p] == DEPTH) err_d[p] = 1'b1;
        else                   cnt_d[p] = cnt_q[p] + ONE;
      end else if (!ret[p] && bus.flit_valid_op[p]) begin
        if (cnt_q[p] == '0) err_d[p] = 1'b1;
        else                cnt_d[p] = cnt_q[p] - ONE;
      end

      // Ownership FSM. A same-cycle alloc plus tail is a complete
      // single-flit packet, so the port never leaves IDLE.
      if (state_q[p] == IDLE) begin
        if (bus.alloc_op[p]) begin
          if (!ready[p]) err_d[p] = 1'b1;
          if (!(bus.flit_valid_op[p] && bus.flit_tail_op[p])) state_d[p] = BUSY;
        end else if (bus.flit_valid_op[p]) begin
          err_d[p] = 1'b1;
        end
      end else begin
        if (bus.alloc_op[p]) begin
          err_d[p] = 1'b1;
        end else if (bus.flit_valid_op[p] && bus.flit_tail_op[p]) begin
          state_d[p] = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned p = 0; p < num_ports; p++) begin
        cnt_q[p]   <= DEPTH;
        state_q[p] <= IDLE;
      end
      err_q   <= '0;
      error_q <= 1'b0;
    end else begin
      for (int unsigned p = 0; p < num_ports; p++) begin
        cnt_q[p]   <= cnt_d[p];
        state_q[p] <= state_d[p];
      end
      err_q   <= err_d;
      error_q <= error_d;
    end
  end

endmodule

// File: tb/tb_shared_vc_credit_ctrl.sv
// Directed self-checking bench for shared_vc_credit_ctrl. Instance a uses
// default parameters; instance b uses credit_delay=2, alloc_threshold=4.
module tb_shared_vc_credit_ctrl;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  shared_vc_credit_ctrl_if #(.num_ports(5), .cnt_width(4)) ia ();
  shared_vc_credit_ctrl_if #(.num_ports(5), .cnt_width(4)) ib ();

  shared_vc_credit_ctrl #(
    .num_ports(5), .shared_buf_depth(8), .credit_delay(1), .alloc_threshold(1)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(ia)
  );

  shared_vc_credit_ctrl #(
    .num_ports(5), .shared_buf_depth(8), .credit_delay(2), .alloc_threshold(4)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(ib)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cnt_of(input logic [19:0] v, input int p);
    return 32'(v[(4-p)*4 +: 4]);
  endfunction

  task automatic clear_inputs();
    ia.credit_for_shared_in = '0; ia.alloc_op = '0; ia.flit_valid_op = '0; ia.flit_tail_op = '0;
    ib.credit_for_shared_in = '0; ib.alloc_op = '0; ib.flit_valid_op = '0; ib.flit_tail_op = '0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cnt"},   32'(ia.credit_count_op), 32'h88888);
    chk({tag, "_avail"}, 32'(ia.shared_credit_avail_op), 32'h1f);
    chk({tag, "_ready"}, 32'(ia.ready_for_allocation_out), 32'h1f);
    chk({tag, "_eop"},   32'(ia.error_op), 32'h0);
    chk({tag, "_err"},   32'(ia.error), 32'h0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    clear_inputs();

    // Reset values while reset is held.
    step();
    chk_reset_vals("rst_held");
    reset = 1'b1;
    repeat (10) step();
    chk_reset_vals("idle10");
    chk("b_cnt_idle",   32'(ib.credit_count_op), 32'h88888);
    chk("b_ready_idle", 32'(ib.ready_for_allocation_out), 32'h1f);

    // Ports 1 and 2 allocate; port 2 sends 8 flits ending in a tail,
    // port 1 sends 8 body flits and stays BUSY.
    ia.alloc_op = 5'b00110;
    step();
    clear_inputs();
    chk("a_ready_alloc", 32'(ia.ready_for_allocation_out), 32'h19);
    for (int i = 0; i < 8; i++) begin
      ia.flit_valid_op = 5'b00110;
      ia.flit_tail_op  = (i == 7) ? 5'b00100 : 5'b00000;
      step();
      chk($sformatf("a_cnt2_f%0d", i), cnt_of(ia.credit_count_op, 2), 32'(7 - i));
      chk($sformatf("a_cnt1_f%0d", i), cnt_of(ia.credit_count_op, 1), 32'(7 - i));
    end
    clear_inputs();
    chk("a_avail_drain", 32'(ia.shared_credit_avail_op), 32'h19);
    chk("a_ready_drain", 32'(ia.ready_for_allocation_out), 32'h19);
    chk("a_eop_drain",   32'(ia.error_op), 32'h0);

    // Port 1 at zero: returned credit meets a flit in the same cycle.
    ia.credit_for_shared_in = 5'b00010;
    step();
    clear_inputs();
    ia.flit_valid_op = 5'b00010;
    step();
    clear_inputs();
    chk("a_cnt1_cancel", cnt_of(ia.credit_count_op, 1), 32'h0);
    chk("a_eop_cancel",  32'(ia.error_op), 32'h0);

    // Port 1 underflow with a tail flit.
    ia.flit_valid_op = 5'b00010;
    ia.flit_tail_op  = 5'b00010;
    step();
    clear_inputs();
    chk("a_eop_uflow",  32'(ia.error_op), 32'h02);
    chk("a_err_uflow0", 32'(ia.error), 32'h0);
    chk("a_cnt1_uflow", cnt_of(ia.credit_count_op, 1), 32'h0);
    step();
    chk("a_err_uflow1", 32'(ia.error), 32'h1);

    // Port 3 overflow from a credit at full count.
    ia.credit_for_shared_in = 5'b01000;
    step();
    clear_inputs();
    chk("a_eop_oflow0", 32'(ia.error_op), 32'h02);
    step();
    chk("a_eop_oflow1", 32'(ia.error_op), 32'h0a);
    chk("a_cnt3_oflow", cnt_of(ia.credit_count_op, 3), 32'h8);

    // Port 4 mid-packet with a port-0 credit in flight, then reset.
    ia.alloc_op = 5'b10000;
    step();
    clear_inputs();
    ia.flit_valid_op        = 5'b10000;
    ia.credit_for_shared_in = 5'b00001;
    step();
    clear_inputs();
    chk("a_cnt4_mid",   cnt_of(ia.credit_count_op, 4), 32'h7);
    chk("a_ready4_mid", 32'(ia.ready_for_allocation_out[4]), 32'h0);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals("rst_mid");
    reset = 1'b1;
    step();
    step();
    chk("a_eop_postrst", 32'(ia.error_op), 32'h0);
    chk("a_cnt_postrst", 32'(ia.credit_count_op), 32'h88888);

    // Instance b: drain port 0 while BUSY.
    ib.alloc_op = 5'b00001;
    step();
    clear_inputs();
    chk("b_ready_alloc", 32'(ib.ready_for_allocation_out), 32'h1e);
    ib.flit_valid_op = 5'b00001;
    repeat (8) step();
    clear_inputs();
    chk("b_cnt0_drain",  cnt_of(ib.credit_count_op, 0), 32'h0);
    chk("b_avail_drain", 32'(ib.shared_credit_avail_op), 32'h1e);

    // Two-stage credit delay.
    ib.credit_for_shared_in = 5'b00001;
    step();
    clear_inputs();
    chk("b_cnt0_d1", cnt_of(ib.credit_count_op, 0), 32'h0);
    step();
    chk("b_cnt0_d2",   cnt_of(ib.credit_count_op, 0), 32'h0);
    chk("b_avail0_d2", 32'(ib.shared_credit_avail_op[0]), 32'h0);
    step();
    chk("b_cnt0_d3",   cnt_of(ib.credit_count_op, 0), 32'h1);
    chk("b_avail_d3",  32'(ib.shared_credit_avail_op), 32'h1f);

    // Tail returns port 0 to IDLE at count 0.
    ib.flit_valid_op = 5'b00001;
    ib.flit_tail_op  = 5'b00001;
    step();
    clear_inputs();
    chk("b_cnt0_tail",  cnt_of(ib.credit_count_op, 0), 32'h0);
    chk("b_ready_tail", 32'(ib.ready_for_allocation_out), 32'h1e);
    chk("b_eop_tail",   32'(ib.error_op), 32'h0);

    // Three credits -> count 3, still below threshold 4.
    ib.credit_for_shared_in = 5'b00001;
    repeat (3) step();
    clear_inputs();
    repeat (2) step();
    chk("b_cnt0_3",   cnt_of(ib.credit_count_op, 0), 32'h3);
    chk("b_ready_3",  32'(ib.ready_for_allocation_out), 32'h1e);

    // One more credit reaches the threshold.
    ib.credit_for_shared_in = 5'b00001;
    step();
    clear_inputs();
    step();
    chk("b_cnt0_3b",  cnt_of(ib.credit_count_op, 0), 32'h3);
    step();
    chk("b_cnt0_4",   cnt_of(ib.credit_count_op, 0), 32'h4);
    chk("b_ready_4",  32'(ib.ready_for_allocation_out), 32'h1f);

    // Single-flit packet: alloc and tail together.
    ib.alloc_op      = 5'b00001;
    ib.flit_valid_op = 5'b00001;
    ib.flit_tail_op  = 5'b00001;
    step();
    clear_inputs();
    chk("b_cnt0_single",   cnt_of(ib.credit_count_op, 0), 32'h3);
    chk("b_ready_single",  32'(ib.ready_for_allocation_out), 32'h1e);
    chk("b_eop_single",    32'(ib.error_op), 32'h0);

    // Refill to threshold: ready only returns if the FSM stayed IDLE.
    ib.credit_for_shared_in = 5'b00001;
    step();
    clear_inputs();
    step();
    step();
    chk("b_cnt0_refill",  cnt_of(ib.credit_count_op, 0), 32'h4);
    chk("b_ready_refill", 32'(ib.ready_for_allocation_out), 32'h1f);
    step();
    chk("b_err_final", 32'(ib.error), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/shared_vc_credit_ctrl.md
# shared_vc_credit_ctrl

Per-output-port credit and allocation controller for the downstream shared VC buffer of the dynamic-VC router. It tracks free shared-buffer slots at each neighbour, using the returned `credit_for_shared_in` pulses and the flits the router launches on the shared VC. It then exports per-port availability and allocation readiness to the VC and switch allocators. This is the parametrised successor of the fixed shared-VC handshake in the synthesis-level router wrapper: port count, buffer depth, credit-return pipeline depth and allocation threshold are all configurable, and the block adds a per-port ownership FSM and sticky error detection.

## Interface
- `num_ports`, 5, number of router output ports tracked.
- `shared_buf_depth`, 8, downstream shared-buffer slots per port; must be ≥1.
- `credit_delay`, 1, register stages on returned credits; range 0..4.
- `alloc_threshold`, 1, minimum credits required to offer a new allocation; range 1..`shared_buf_depth`.
- Derived: `cnt_width` = clogb(`shared_buf_depth`+1).
- `clk`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-low reset.
- `credit_for_shared_in`  in  `num_ports`  one-cycle pulse per port; one slot freed downstream.
- `alloc_op`  in  `num_ports`  one-cycle pulse; allocator claims the shared VC of the port for a packet.
- `flit_valid_op`  in  `num_ports`  one-cycle pulse; a flit is sent on the shared VC.
- `flit_tail_op`  in  `num_ports`  qualifies `flit_valid_op`; the flit is a tail.
- `shared_credit_avail_op`  out  `num_ports`  the count for the port is non-zero.
- `ready_for_allocation_out`  out  `num_ports`  the port is IDLE and its count is ≥ `alloc_threshold`.
- `credit_count_op`  out  `num_ports*cnt_width`  current count per port; port 0 is in the MSBs.
- `error_op`  out  `num_ports`  sticky per-port error.
- `error`  out  1  OR of `error_op`, registered.

## Operation
- Each port is independent. Per port p the block holds:
  - a counter `cnt[p]`;
  - a `credit_delay`-stage shift register on `credit_for_shared_in[p]`;
  - a 2-state FSM;
  - a sticky error bit.
- The delayed credit `ret[p]` is the output of the shift register. With `credit_delay`=0, `ret[p]` is the raw input.
- Counter update each cycle:
  - `ret` & !`flit_valid`: increment.
  - !`ret` & `flit_valid`: decrement.
  - both or neither: hold.
- Overflow: an increment at `cnt`=`shared_buf_depth` saturates (count holds) and sets `error_op[p]`.
- Underflow: a decrement at `cnt`=0 holds the count at 0 and sets `error_op[p]`.
  - A same-cycle `ret` and `flit_valid` at `cnt`=0 is legal; the count stays 0 and no error is flagged.
- FSM states:
  - IDLE → BUSY on `alloc_op`.
  - BUSY → IDLE on `flit_valid_op` & `flit_tail_op`.
  - A single-flit packet may allocate and send its tail flit in the same cycle; the FSM stays IDLE.
- FSM errors (all set `error_op[p]`):
  - `alloc_op` while BUSY. The state stays BUSY.
  - `alloc_op` while `ready_for_allocation_out[p]`=0 in IDLE. The transition is still taken.
  - `flit_valid_op` in IDLE without a same-cycle `alloc_op`. The count still decrements.
- `flit_tail_op` without `flit_valid_op` is ignored.
- Error bits clear only on reset.

## Timing
- Reset values (asynchronous, while `reset`=0):
  - every `cnt` = `shared_buf_depth`;
  - credit shift registers = 0;
  - FSM = IDLE;
  - `error_op` = 0 and `error` = 0;
  - therefore `shared_credit_avail_op` = all 1s and `ready_for_allocation_out` = all 1s.
- Reset deassertion takes effect at the next `clk` edge. Pulses on the deassertion edge are ignored.
- Reset asserted mid-packet immediately returns all state to its reset values; in-flight delayed credits are discarded.
- All outputs except `error` are combinational decodes of registered state; there is no input-to-output combinational path.
- Latencies:
  - A credit pulse in cycle t changes `cnt` at edge t+1+`credit_delay`.
  - `flit_valid_op` in cycle t changes `cnt` at edge t+1.
  - `alloc_op` in cycle t drops `ready_for_allocation_out` from cycle t+1.
  - The tail flit in cycle t restores `ready_for_allocation_out` from cycle t+1, provided the threshold is met.
  - `error_op` asserts the cycle after the offending event; `error` asserts one cycle after that.

## Test plan
- Reset, then idle for 10 cycles → all counts 8, avail = 5'b11111, ready = 5'b11111, error = 0.
- Port 2: alloc, then 8 flits (the last a tail) with no credits → `cnt[2]` steps 7..0; avail[2] = 0 after the 8th flit; ready[2] = 0; no error.
- `credit_delay`=2, `cnt[0]`=0: a credit pulse in cycle 10 → `cnt[0]`=1 first visible in cycle 13; avail[0] rises in cycle 13.
- `cnt[1]`=0: credit return and flit in the same cycle → count stays 0, error_op[1] = 0. A further flit with no credit → error_op[1] = 1 the next cycle, error = 1 one cycle later, count stays 0.
- Port 3 at `cnt`=8: an extra credit → count saturates at 8, error_op[3] = 1. Assert reset mid-packet on port 4 → all state returns to reset values immediately.
- `alloc_threshold`=4, `cnt[0]`=3 → ready[0] = 0. One credit returns → ready[0] = 1 the following cycle. Alloc and a single-flit tail in the same cycle → FSM stays IDLE, `cnt[0]`=3.
